// File: rtl/vmicro16_apb_timer.sv
// vmicro16_apb_timer: APB3 completer wrapping a 16-bit down-counting timer with a level irq.
// Defining VMICRO16_TIMER_PRESCALER_EN adds the PRESC register (offset 4) and a tick prescaler.
module vmicro16_apb_timer #(
  parameter int BUS_WIDTH  = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] S_PADDR,
  input  logic                  S_PWRITE,
  input  logic                  S_PSELx,
  input  logic                  S_PENABLE,
  input  logic [BUS_WIDTH-1:0]  S_PWDATA,
  output logic [BUS_WIDTH-1:0]  S_PRDATA,
  output logic                  S_PREADY,
  output logic                  S_PSLVERR,
  output logic                  irq
);
  localparam logic [2:0]           OFF_CTRL   = 3'd0;
  localparam logic [2:0]           OFF_LOAD   = 3'd1;
  localparam logic [2:0]           OFF_COUNT  = 3'd2;
  localparam logic [2:0]           OFF_STATUS = 3'd3;
  localparam logic [2:0]           OFF_PRESC  = 3'd4;
  localparam logic [BUS_WIDTH-1:0] ZERO       = {BUS_WIDTH{1'b0}};
  localparam logic [BUS_WIDTH-1:0] ONE        = {{(BUS_WIDTH-1){1'b0}}, 1'b1};

  logic [2:0]           ctrl_q, ctrl_d;
  logic [BUS_WIDTH-1:0] load_q, load_d, count_q, count_d, prdata_q, prdata_d;
  logic                 exp_q, exp_d, pready_q, pready_d, pslverr_q, pslverr_d, irq_q, irq_d;
  logic [2:0]           off_s;
  logic                 mapped_s, setup_s, access_s, wr_s, en_clear_s, ps_hit_s, tick_s;
  logic [BUS_WIDTH-1:0] rdata_s, presc_rd_s;
  logic                 paddr_unused_s;

  assign off_s          = S_PADDR[2:0];
  assign paddr_unused_s = ^S_PADDR[ADDR_WIDTH-1:3];
  assign setup_s        = S_PSELx & ~S_PENABLE;
  assign access_s       = S_PSELx & S_PENABLE & pready_q;
  assign wr_s           = access_s & S_PWRITE & mapped_s;
  assign en_clear_s     = wr_s & (off_s == OFF_CTRL) & ~S_PWDATA[0];
  assign tick_s         = ctrl_q[0] & ps_hit_s & ~en_clear_s;

`ifdef VMICRO16_TIMER_PRESCALER_EN
  logic [BUS_WIDTH-1:0] presc_q, presc_d, pscnt_q, pscnt_d;

  assign mapped_s   = (off_s <= OFF_PRESC);
  assign presc_rd_s = presc_q;

  // Prescaler: counts enabled clocks, fires a tick when it reaches PRESC.
  always_comb begin
    presc_d  = presc_q;
    pscnt_d  = pscnt_q;
    ps_hit_s = 1'b0;
    if (!ctrl_q[0]) begin
      pscnt_d = ZERO;
    end else if (pscnt_q == presc_q) begin
      ps_hit_s = 1'b1;
      pscnt_d  = ZERO;
    end else begin
      pscnt_d = pscnt_q + ONE;
    end
    if (wr_s && (off_s == OFF_PRESC)) begin
      presc_d = S_PWDATA;
      pscnt_d = ZERO;
    end else begin
      presc_d = presc_d;
    end
  end

  // Prescaler state registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      presc_q <= ZERO;
      pscnt_q <= ZERO;
    end else begin
      presc_q <= presc_d;
      pscnt_q <= pscnt_d;
    end
  end
`else
  assign mapped_s   = (off_s <= OFF_STATUS);
  assign presc_rd_s = ZERO;
  assign ps_hit_s   = 1'b1;
`endif

  // Read mux for the setup phase; unmapped offsets read as zero.
  always_comb begin
    case (off_s)
      OFF_CTRL:   rdata_s = {{(BUS_WIDTH-3){1'b0}}, ctrl_q};
      OFF_LOAD:   rdata_s = load_q;
      OFF_COUNT:  rdata_s = count_q;
      OFF_STATUS: rdata_s = {{(BUS_WIDTH-1){1'b0}}, exp_q};
      OFF_PRESC:  rdata_s = presc_rd_s;
      default:    rdata_s = ZERO;
    endcase
  end

  // Timer and register next-state; bus writes are applied after the tick so they win.
  always_comb begin
    ctrl_d  = ctrl_q;
    load_d  = load_q;
    count_d = count_q;
    exp_d   = exp_q;
    if (tick_s) begin
      if (count_q != ZERO) begin
        count_d = count_q - ONE;
      end else if (ctrl_q[1]) begin
        count_d = load_q;
      end else begin
        ctrl_d[0] = 1'b0;
      end
    end else begin
      count_d = count_q;
    end
    if (wr_s) begin
      case (off_s)
        OFF_CTRL:   ctrl_d = S_PWDATA[2:0];
        OFF_LOAD: begin
          load_d  = S_PWDATA;
          count_d = S_PWDATA;
        end
        OFF_STATUS: exp_d = exp_q & ~S_PWDATA[0];
        default:    exp_d = exp_q;
      endcase
    end else begin
      exp_d = exp_q;
    end
    // Expiry overrides a same-cycle W1C.
    if (tick_s && (count_q == ZERO)) begin
      exp_d = 1'b1;
    end else begin
      exp_d = exp_d;
    end
  end

  // APB handshake: setup registers read data and raises PREADY for one access cycle.
  always_comb begin
    pready_d  = setup_s;
    pslverr_d = setup_s & ~mapped_s;
    irq_d     = exp_q & ctrl_q[2];
    if (setup_s) begin
      prdata_d = rdata_s;
    end else begin
      prdata_d = prdata_q;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ctrl_q    <= 3'd0;
      load_q    <= ZERO;
      count_q   <= ZERO;
      exp_q     <= 1'b0;
      prdata_q  <= ZERO;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      ctrl_q    <= ctrl_d;
      load_q    <= load_d;
      count_q   <= count_d;
      exp_q     <= exp_d;
      prdata_q  <= prdata_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      irq_q     <= irq_d;
    end
  end

  assign S_PRDATA  = prdata_q;
  assign S_PREADY  = pready_q;
  assign S_PSLVERR = pslverr_q;
  assign irq       = irq_q;
endmodule

// File: tb/tb_vmicro16_apb_timer.sv
// Self-checking bench for vmicro16_apb_timer: directed scenarios plus random APB traffic,
// every cycle compared against a behavioural model of the register/timer rules.
module tb_vmicro16_apb_timer;
`ifdef VMICRO16_TIMER_PRESCALER_EN
  localparam bit HAS_PRESC = 1'b1;
`else
  localparam bit HAS_PRESC = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  paddr;
  logic        pwrite, psel, penable;
  logic [15:0] pwdata;
  logic [15:0] prdata;
  logic        pready, pslverr, irq;

  int n_total = 0;
  int n_bad   = 0;

  // model state
  bit m_en, m_auto, m_ie, m_exp, m_irq, m_pready, m_pslverr;
  int m_load, m_count, m_presc, m_ps, m_prdata;

  vmicro16_apb_timer #(.BUS_WIDTH(16), .ADDR_WIDTH(4)) dut (
    .clk(clk), .reset(rst_n), .S_PADDR(paddr), .S_PWRITE(pwrite), .S_PSELx(psel),
    .S_PENABLE(penable), .S_PWDATA(pwdata), .S_PRDATA(prdata), .S_PREADY(pready),
    .S_PSLVERR(pslverr), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance the model by one rising edge using the inputs currently on the bus.
  task automatic model_step();
    int  off, rd, n_count, n_load, n_presc, n_ps;
    bit  mapped, setup, access, wr, tick, expire, n_en, n_auto, n_ie, n_exp;
    if (!rst_n) begin
      {m_en, m_auto, m_ie, m_exp, m_irq, m_pready, m_pslverr} = '0;
      m_load = 0; m_count = 0; m_presc = 0; m_ps = 0; m_prdata = 0;
      return;
    end
    off    = int'(paddr) % 8;
    mapped = (off <= 3) || (HAS_PRESC && off == 4);
    setup  = psel && !penable;
    access = psel && penable && m_pready;
    wr     = access && pwrite && mapped;
    case (off)
      0: rd = int'(m_en) + 2 * int'(m_auto) + 4 * int'(m_ie);
      1: rd = m_load;
      2: rd = m_count;
      3: rd = int'(m_exp);
      4: rd = HAS_PRESC ? m_presc : 0;
      default: rd = 0;
    endcase
    n_en = m_en; n_auto = m_auto; n_ie = m_ie; n_exp = m_exp;
    n_load = m_load; n_count = m_count; n_presc = m_presc; n_ps = m_ps;
    if (!m_en) begin
      tick = 0; n_ps = 0;
    end else if (!HAS_PRESC || m_ps == m_presc) begin
      tick = 1; n_ps = 0;
    end else begin
      tick = 0; n_ps = m_ps + 1;
    end
    if (wr && off == 0 && pwdata[0] == 1'b0) tick = 0;
    expire = tick && (m_count == 0);
    if (tick) begin
      if (m_count > 0) n_count = m_count - 1;
      else if (m_auto) n_count = m_load;
      else n_en = 0;
    end
    if (expire) n_exp = 1;
    if (wr) begin
      case (off)
        0: begin n_en = pwdata[0]; n_auto = pwdata[1]; n_ie = pwdata[2]; end
        1: begin n_load = int'(pwdata); n_count = int'(pwdata); end
        3: if (pwdata[0] && !expire) n_exp = 0;
        4: begin n_presc = int'(pwdata); n_ps = 0; end
        default: ;
      endcase
    end
    m_irq = m_exp && m_ie;
    if (setup) m_prdata = rd;
    m_pready = setup;
    m_pslverr = setup && !mapped;
    m_en = n_en; m_auto = n_auto; m_ie = n_ie; m_exp = n_exp;
    m_load = n_load; m_count = n_count; m_presc = n_presc; m_ps = n_ps;
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    check_val("pready", 32'(pready), 32'(m_pready));
    check_val("pslverr", 32'(pslverr), 32'(m_pslverr));
    check_val("irq", 32'(irq), 32'(m_irq));
    if (m_pready) check_val("prdata", 32'(prdata), 32'(m_prdata));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
      step();
    end
  endtask

  task automatic apb_xfer(input bit wr, input int addr, input int data,
                          output logic [15:0] rdata, output logic err);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = 4'(addr); pwdata = 16'(data);
    step();
    rdata = prdata; err = pslverr;
    penable = 1'b1;
    step();
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic wr_reg(input int addr, input int data);
    logic [15:0] d; logic e;
    apb_xfer(1'b1, addr, data, d, e);
  endtask

  task automatic rd_chk(input string tag, input int addr, input int exp);
    logic [15:0] d; logic e;
    apb_xfer(1'b0, addr, 0, d, e);
    check_val(tag, 32'(d), 32'(exp));
  endtask

  initial begin
    logic [15:0] d;
    logic        e;
    int          act, off, dat;
    rst_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = 4'd0; pwdata = 16'd0;
    for (int i = 0; i < 4; i++) step();
    check_val("rst_prdata", 32'(prdata), 32'd0);
    check_val("rst_irq", 32'(irq), 32'd0);
    rst_n = 1'b1;
    for (int a = 0; a < 4; a++) begin
      apb_xfer(1'b0, a, 0, d, e);
      check_val("rst_read", 32'(d), 32'd0);
      check_val("rst_err", 32'(e), 32'd0);
    end

    // one-shot with irq
    wr_reg(1, 5);
    wr_reg(0, 5);
    step();
    rd_chk("t2_cnt4", 2, 4);
    rd_chk("t2_cnt2", 2, 2);
    idle(6);
    rd_chk("t2_exp", 3, 1);
    rd_chk("t2_ctrl", 0, 4);
    check_val("t2_irq", 32'(irq), 32'd1);
    wr_reg(3, 1);
    rd_chk("t4_w1c", 3, 0);
    check_val("t4_irq_drop", 32'(irq), 32'd0);

    // auto-reload
    wr_reg(1, 2);
    wr_reg(0, 3);
    idle(20);
    rd_chk("t3_ctrl", 0, 3);
    rd_chk("t3_exp", 3, 1);

    // W1C colliding with expiry: LOAD=0 with AUTO expires on every tick
    wr_reg(1, 0);
    idle(2);
    wr_reg(3, 1);
    rd_chk("t4_setwins", 3, 1);
    wr_reg(0, 0);
    wr_reg(3, 1);
    rd_chk("t4_clr", 3, 0);

    // unmapped offset and read-only COUNT
    apb_xfer(1'b1, 6, 16'hFFFF, d, e);
    check_val("t5_werr", 32'(e), 32'd1);
    apb_xfer(1'b0, 6, 0, d, e);
    check_val("t5_rerr", 32'(e), 32'd1);
    check_val("t5_rdata", 32'(d), 32'd0);
    apb_xfer(1'b1, 2, 16'h1234, d, e);
    check_val("t5_cnt_err", 32'(e), 32'd0);
    rd_chk("t5_cnt", 2, 0);
    rd_chk("t5_ctrl", 0, 0);

`ifdef VMICRO16_TIMER_PRESCALER_EN
    wr_reg(4, 3);
    wr_reg(1, 1);
    wr_reg(0, 1);
    idle(4);
    rd_chk("t6_cnt", 2, 0);
    rd_chk("t6_noexp", 3, 0);
    idle(4);
    rd_chk("t6_exp", 3, 1);
    rd_chk("t6_presc", 4, 3);
`else
    apb_xfer(1'b0, 4, 0, d, e);
    check_val("t6_err", 32'(e), 32'd1);
    check_val("t6_rdata", 32'(d), 32'd0);
`endif

    // random traffic against the model
    for (int it = 0; it < 600; it++) begin
      act = $urandom_range(0, 99);
      off = $urandom_range(0, 15);
      case (off % 8)
        0: dat = $urandom_range(0, 7);
        1, 4: dat = $urandom_range(0, 6);
        3: dat = $urandom_range(0, 1);
        default: dat = $urandom_range(0, 65535);
      endcase
      if (act < 70) begin
        apb_xfer(1'($urandom_range(0, 1)), off, dat, d, e);
      end else if (act < 85) begin
        idle($urandom_range(1, 5));
      end else if (act < 96) begin
        psel = 1'b1; penable = 1'b0; pwrite = 1'($urandom_range(0, 1));
        paddr = 4'(off); pwdata = 16'(dat);
        step();
        psel = 1'b0; penable = 1'($urandom_range(0, 1));
        step();
        penable = 1'b0;
      end else begin
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 4'(off); pwdata = 16'(dat);
        step();
        rst_n = 1'b0; penable = 1'b1;
        step();
        rst_n = 1'b1; psel = 1'b0; penable = 1'b0;
        step();
      end
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
